display_scan_controller: RTL and testbench



---
 rtl/display_pkg.sv | 19 +
 rtl/scan_timer.sv | 38 +++
 rtl/display_scan_controller.sv | 130 +++++++++++++
 tb/tb_display_scan_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed score display.
// Used by display_scan_controller and scan_timer.
package display_pkg;

    typedef enum logic {
        GAP = 1'b0,
        ON  = 1'b1
    } scan_state_e;

    typedef logic [3:0] bcd_nibble;

    localparam bcd_nibble BCD_MAX = 4'd9;

    localparam int MAX_DIGITS = 16;

    // Sliced down to NUM_DIGITS by the controller
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/scan_timer.sv
// Free-running slot counter: cycles 0..BLANK_CYCLES-1 form the gap,
// the rest of each PRESCALE-cycle slot is the on-time.
module scan_timer
    import display_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic reset,
    output logic gap_done,
    output logic on_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign gap_done = (cnt_q == CW'(BLANK_CYCLES - 1));
    assign on_done  = (cnt_q == CW'(PRESCALE - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (on_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed BCD score display scanner with double-buffered score word.
// Optional leading-zero suppression: define SCAN_LZ_SUPPRESS_EN.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [NUM_DIGITS*4-1:0] load_data,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   digit_anode,
    output logic                    frame_start
);

    localparam int DW = NUM_DIGITS * 4;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = ANODE_OFF[NUM_DIGITS-1:0];

    scan_state_e           state_q;
    logic [IW-1:0]         idx_q;
    logic [DW-1:0]         active_q;
    logic [DW-1:0]         pend_buf_q;
    logic                  pend_q;
    bcd_nibble             bcd_q;
    logic [NUM_DIGITS-1:0] anode_q;
    logic                  fs_q;

    logic gap_done;
    logic on_done;

    scan_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .gap_done (gap_done),
        .on_done  (on_done)
    );

    logic                  wrap_d;
    logic [IW-1:0]         idx_d;
    logic [DW-1:0]         active_d;
    bcd_nibble             bcd_d;
    logic                  show_d;
    logic [NUM_DIGITS-1:0] anode_d;

    // Look ahead to the digit and buffer that the next ON slot will use,
    // so the commit and the first digit 0 slot land on the same edge.
    always_comb begin
        wrap_d   = (idx_q == LAST_IDX);
        idx_d    = wrap_d ? '0 : idx_q + 1'b1;
        active_d = (wrap_d && pend_q) ? pend_buf_q : active_q;
        bcd_d    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_d) begin
                bcd_d = active_d[i*4 +: 4];
            end
        end
        show_d = (bcd_d <= BCD_MAX);
`ifdef SCAN_LZ_SUPPRESS_EN
        begin
            logic hi_zero;
            hi_zero = 1'b1;
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                hi_zero = hi_zero && (active_d[i*4 +: 4] == 4'd0);
                if ((IW'(i) == idx_d) && hi_zero) begin
                    show_d = 1'b0;
                end
            end
        end
`endif
        anode_d = ALL_OFF;
        if (show_d) begin
            anode_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= GAP;
            idx_q      <= LAST_IDX;
            active_q   <= '0;
            pend_buf_q <= '0;
            pend_q     <= 1'b0;
            bcd_q      <= '0;
            anode_q    <= ALL_OFF;
            fs_q       <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            if (load_valid && !pend_q) begin
                pend_buf_q <= load_data;
                pend_q     <= 1'b1;
            end
            unique case (state_q)
                GAP: begin
                    if (gap_done) begin
                        state_q <= ON;
                        idx_q   <= idx_d;
                        bcd_q   <= bcd_d;
                        anode_q <= anode_d;
                        fs_q    <= (idx_d == '0);
                        if (wrap_d && pend_q) begin
                            active_q <= pend_buf_q;
                            pend_q   <= 1'b0;
                        end
                    end
                end
                ON: begin
                    if (on_done) begin
                        state_q <= GAP;
                        anode_q <= ALL_OFF;
                    end
                end
            endcase
        end
    end

    assign load_ready  = !pend_q;
    assign digit_bcd   = bcd_q;
    assign digit_anode = anode_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (ND=4, PRESCALE=8, BLANK=2).
// Frames are predicted from slot arithmetic and the committed score word.
module tb_display_scan_controller;

    localparam int ND = 4;
    localparam int P  = 8;
    localparam int BL = 2;
    localparam int FRAME = ND * P;

    typedef struct {
        logic       fs;
        logic [3:0] bcd;
        logic [3:0] an;
    } slot_t;

    logic          clk;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [15:0]   load_data;
    logic [3:0]    digit_bcd;
    logic [3:0]    digit_anode;
    logic          frame_start;

    display_scan_controller #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (P),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .digit_bcd   (digit_bcd),
        .digit_anode (digit_anode),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 1;
    bit          pend_m = 0;
    logic [15:0] pend_val = 0;
    logic [15:0] comm = 0;
    slot_t       sq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic void push_frame(input logic [15:0] v);
        slot_t s;
        for (int i = 0; i < ND; i++) begin
            bit blank;
            s.bcd = v[i*4 +: 4];
            blank = (s.bcd > 4'd9);
`ifdef SCAN_LZ_SUPPRESS_EN
            if (i > 0 && (v >> (4 * i)) == 16'd0) blank = 1;
`endif
            s.an = blank ? 4'hF : ~(4'b0001 << i);
            s.fs = (i == 0);
            sq.push_back(s);
        end
    endfunction

    // Reference model: cyc is the cycle number after the reset edge
    always @(posedge clk) begin
        if (reset) begin
            cyc = 1;
            pend_m = 0;
            pend_val = 0;
            comm = 0;
            sq.delete();
        end else begin
            bit bnd;
            bit acc;
            bnd = (cyc >= BL) && ((cyc - BL) % FRAME == 0);
            acc = load_valid && !pend_m;
            if (bnd && pend_m) begin
                comm = pend_val;
                pend_m = 0;
            end
            if (acc) begin
                pend_m = 1;
                pend_val = load_data;
            end
            if (bnd) push_frame(comm);
            cyc++;
        end
    end

    // Monitor
    always @(negedge clk) begin
        int  p;
        bit  on;
        p  = (cyc - 1) % P;
        on = (p >= BL);
        chk("load_ready", load_ready, !pend_m);
        if (cyc <= BL) chk("bcd_after_reset", digit_bcd, 0);
        if (on) begin
            if (sq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL queue_empty cycle=%0d actual=none required=slot",
                         cyc);
            end else begin
                chk("bcd", digit_bcd, sq[0].bcd);
                chk("anode", digit_anode, sq[0].an);
                chk("frame_start", frame_start, sq[0].fs && (p == BL));
                if (p == P - 1) void'(sq.pop_front());
            end
        end else begin
            chk("gap_anode", digit_anode, 4'hF);
            chk("gap_frame_start", frame_start, 0);
        end
    end

    task automatic send(input logic [15:0] d);
        bit ok;
        ok = 0;
        load_data = d;
        load_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = load_ready;
            @(negedge clk);
        end
        load_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=stalled required=accept data=%0h",
                     d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        load_valid = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < ND; i++) begin
            w[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        case ($urandom_range(0, 5))
            0: w[($urandom_range(0, 3))*4 +: 4] = 4'($urandom_range(10, 15));
            1: w = w & 16'h00FF;
            2: w = w & 16'h000F;
            3: w = 16'h0000;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        reset = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        idle(3);
        reset = 1'b0;
        idle(40);
        send(16'h1234);
        idle(70);
        idle(10);
        send(16'h1234);
        send(16'h5678);
        idle(80);
        send(16'h0A55);
        idle(70);
        idle(2 * P + BL + 2);
        pulse_reset(1);
        idle(45);
        send(16'h0007);
        idle(70);
        send(16'h0000);
        idle(70);
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 30) == 0) pulse_reset($urandom_range(1, 3));
            idle($urandom_range(0, 40));
            send(rand_word());
        end
        idle(80);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
